// File: rtl/note_source_arbiter_if.sv
// Handshake bundle between the note source arbiter and its environment.
// slave  : the arbiter (takes live keyboard, song requests and player
//          outputs; drives player resets and the tone path).
// master : the environment (keyboard, song selector, players, tone path).
// Signals:
//   man_key_on/man_key   live keyboard key and code
//   play_req/song_sel    one-cycle song request and its index
//   stop_req             one-cycle stop request
//   src_key_on/src_key   per-player tone outputs (player n: key[4n+3:4n])
//   src_rst              per-player reset, high holds a player at note 0
//   key_on/key           shared tone path
//   mode                 00 IDLE, 01 MANUAL, 10 SONG, 11 GAP
//   cur_song             active or last song index
interface note_source_arbiter_if #(
    parameter int NUM_SONGS = 4,
    parameter int SW        = $clog2(NUM_SONGS)
);
    logic                   man_key_on;
    logic [3:0]             man_key;
    logic                   play_req;
    logic [SW-1:0]          song_sel;
    logic                   stop_req;
    logic [NUM_SONGS-1:0]   src_key_on;
    logic [4*NUM_SONGS-1:0] src_key;
    logic [NUM_SONGS-1:0]   src_rst;
    logic                   key_on;
    logic [3:0]             key;
    logic [1:0]             mode;
    logic [SW-1:0]          cur_song;

    modport master (
        output man_key_on, man_key, play_req, song_sel, stop_req,
               src_key_on, src_key,
        input  src_rst, key_on, key, mode, cur_song
    );

    modport slave (
        input  man_key_on, man_key, play_req, song_sel, stop_req,
               src_key_on, src_key,
        output src_rst, key_on, key, mode, cur_song
    );
endinterface

// File: rtl/note_source_arbiter.sv
// Shares one tone path between the live keyboard and NUM_SONGS looping song
// players. Idle players are held in reset; exactly one is released while a
// song plays. Live keys preempt playback and every change of source passes
// through a silent gap of GAP_CYCLES cycles.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  note_source_arbiter_if.slave (see interface header)
// All outputs are registered.
module note_source_arbiter #(
    parameter int NUM_SONGS  = 4,
    parameter int GAP_CYCLES = 5_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    note_source_arbiter_if.slave  bus
);
    localparam int              SW          = $clog2(NUM_SONGS);
    localparam logic [SW:0]     NUM_SONGS_W = (SW+1)'(NUM_SONGS);
    localparam logic [25:0]     GAP_LAST    = 26'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MANUAL = 2'b01,
        SONG   = 2'b10,
        GAP    = 2'b11
    } state_t;

    state_t                 state, state_n;
    logic                   key_on_q, key_on_n;
    logic [3:0]             key_q, key_n;
    logic [NUM_SONGS-1:0]   src_rst_q, src_rst_n;
    logic [SW-1:0]          cur_song_q, cur_song_n;
    logic                   pend_vld, pend_vld_n;
    logic [SW-1:0]          pend_idx, pend_idx_n;
    logic [25:0]            gap_cnt, gap_cnt_n;
    logic                   play_ok;

    // All players in reset except the selected one.
    function automatic logic [NUM_SONGS-1:0] release_mask(input logic [SW-1:0] idx);
        release_mask      = '1;
        release_mask[idx] = 1'b0;
    endfunction

    // Out-of-range indices are dropped everywhere.
    assign play_ok = bus.play_req && ({1'b0, bus.song_sel} < NUM_SONGS_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            key_on_q   <= 1'b0;
            key_q      <= 4'd0;
            src_rst_q  <= '1;
            cur_song_q <= '0;
            pend_vld   <= 1'b0;
            pend_idx   <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_n;
            key_on_q   <= key_on_n;
            key_q      <= key_n;
            src_rst_q  <= src_rst_n;
            cur_song_q <= cur_song_n;
            pend_vld   <= pend_vld_n;
            pend_idx   <= pend_idx_n;
            gap_cnt    <= gap_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        key_on_n   = 1'b0;
        key_n      = key_q;
        src_rst_n  = src_rst_q;
        cur_song_n = cur_song_q;
        pend_vld_n = pend_vld;
        pend_idx_n = pend_idx;
        gap_cnt_n  = gap_cnt;

        unique case (state)
            IDLE: begin
                src_rst_n = '1;
                if (bus.man_key_on) begin
                    state_n  = MANUAL;
                    key_on_n = 1'b1;
                    key_n    = bus.man_key;
                end else if (play_ok) begin
                    state_n    = SONG;
                    cur_song_n = bus.song_sel;
                    src_rst_n  = release_mask(bus.song_sel);
                end
            end

            MANUAL: begin
                if (bus.man_key_on) begin
                    key_on_n = 1'b1;
                    key_n    = bus.man_key;
                end else begin
                    state_n   = GAP;
                    gap_cnt_n = '0;
                end
            end

            SONG: begin
                if (bus.man_key_on || bus.stop_req || play_ok) begin
                    // Any exit re-arms all player resets on the GAP edge;
                    // a request (even for the same song) restarts it after the gap.
                    state_n    = GAP;
                    gap_cnt_n  = '0;
                    src_rst_n  = '1;
                    pend_vld_n = !(bus.man_key_on || bus.stop_req);
                    pend_idx_n = bus.song_sel;
                end else begin
                    key_on_n = bus.src_key_on[cur_song_q];
                    key_n    = bus.src_key[{cur_song_q, 2'b00} +: 4];
                end
            end

            GAP: begin
                src_rst_n = '1;
                if (bus.stop_req) begin
                    pend_vld_n = 1'b0;
                end else if (play_ok) begin
                    pend_vld_n = 1'b1;
                    pend_idx_n = bus.song_sel;
                end

                if (gap_cnt == GAP_LAST) begin
                    // Exit uses the pending value as updated this very cycle.
                    gap_cnt_n = '0;
                    if (bus.man_key_on) begin
                        state_n    = MANUAL;
                        pend_vld_n = 1'b0;
                        key_on_n   = 1'b1;
                        key_n      = bus.man_key;
                    end else if (pend_vld_n) begin
                        state_n    = SONG;
                        cur_song_n = pend_idx_n;
                        src_rst_n  = release_mask(pend_idx_n);
                        pend_vld_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + 26'd1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign bus.key_on   = key_on_q;
    assign bus.key      = key_q;
    assign bus.src_rst  = src_rst_q;
    assign bus.mode     = state;
    assign bus.cur_song = cur_song_q;
endmodule

// File: doc/note_source_arbiter.md
# note_source_arbiter

Shares the single piano tone path (`key_on`/`key`) between the live keyboard and `NUM_SONGS` autoplay song players. Each player runs from clock and its own reset, and loops its song forever. The arbiter holds idle players in reset and releases exactly one when a song is requested. Live keys preempt playback, and every source change inserts a silent gap.

## Interface
- `NUM_SONGS`, default 4: number of song players; must be ≥2. `SW = $clog2(NUM_SONGS)`.
- `GAP_CYCLES`, default 5_000_000: silent cycles between sources (50 ms at 100 MHz); must be ≥1. The counter is 26 bits.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `man_key_on` in 1: live keyboard key pressed (already synchronized).
- `man_key` in 4: live keyboard key code.
- `play_req` in 1: one-cycle pulse requesting song `song_sel`.
- `song_sel` in SW: song index. Values ≥`NUM_SONGS` are ignored.
- `stop_req` in 1: one-cycle pulse that stops playback.
- `src_key_on` in NUM_SONGS: per-player `key_on`.
- `src_key` in 4*NUM_SONGS: per-player key; player n uses bits [4n+3:4n].
- `src_rst` out NUM_SONGS: per-player reset. High means the player is held at note 0.
- `key_on` out 1: key_on to the tone generator.
- `key` out 4: key to the tone generator.
- `mode` out 2: state code, 00 IDLE, 01 MANUAL, 10 SONG, 11 GAP.
- `cur_song` out SW: index of the active or last song.

## Operation
- **Registered outputs.** All outputs are registered.
- **Reset values.** On reset, state becomes IDLE and `key_on`=0, `key`=0, `src_rst`=all ones, `mode`=00, `cur_song`=0. The pending flag and `gap_cnt` are cleared.
- **IDLE.**
  - `key_on`=0.
  - If `man_key_on` is high, go to MANUAL.
  - Otherwise, if `play_req` is high and `song_sel` is valid, set `cur_song`=`song_sel`, deassert `src_rst[song_sel]` and go to SONG.
  - `stop_req` has no effect.
- **MANUAL.**
  - `key_on`/`key` follow `man_key_on`/`man_key`.
  - `play_req` is ignored.
  - When `man_key_on`=0, go to GAP.
- **SONG.**
  - `key_on`/`key` follow `src_key_on[cur_song]`/`src_key[cur_song]`.
  - The other players remain in reset.
  - Priority when events coincide: `man_key_on` > `stop_req` > valid `play_req`.
  - `man_key_on` high: go to GAP and clear pending. This is a preemption.
  - `stop_req`: go to GAP and clear pending.
  - Valid `play_req` (any index, including the current one): latch the index as pending, then go to GAP. The song restarts from note 0 after the gap.
  - On every exit from SONG, `src_rst` returns to all ones on the same edge that sets state to GAP.
- **GAP.**
  - `key_on`=0, `key` holds its last value, `src_rst`=all ones.
  - `gap_cnt` counts from 0 up to `GAP_CYCLES-1`.
  - A valid `play_req` overwrites pending (last request wins).
  - `stop_req` clears pending. If it coincides with `play_req`, `stop_req` wins.
- **Leaving GAP.** On the cycle with `gap_cnt`=`GAP_CYCLES-1`:
  - If `man_key_on` is high, go to MANUAL and discard pending.
  - Otherwise, if pending is set, go to SONG with `cur_song`=pending index, deassert that player's `src_rst` and clear pending.
  - Otherwise, go to IDLE.
- **Invalid selection.** A `play_req` with `song_sel`≥`NUM_SONGS` is dropped in every state and never changes pending or `cur_song`.
- **Reset mid-operation.** Reset mid-song or mid-gap immediately returns all outputs to their reset values. All players go back into reset.

## Timing
- **Entry into SONG.** The `mode`, `src_rst` and `cur_song` updates occur on the same clock edge that enters SONG.
- **Pass-through latency.** There is 1 cycle of latency from `man_key_on`/`man_key` or the selected `src_key_on`/`src_key` to `key_on`/`key`.
- **MANUAL → GAP.** If `man_key_on` falls at cycle t, `mode`=11 and `key_on`=0 from edge t+1.
- **Gap length.** GAP lasts exactly `GAP_CYCLES` cycles. The next state appears on edge `GAP_CYCLES` after entry.
- **Request at the GAP → IDLE edge.** A `play_req` sampled on the last GAP cycle is captured as pending and is honoured on that same exit.
- **Request in IDLE.** A `play_req` pulse starts SONG on the next edge.
- **Request in MANUAL.** A `play_req` pulse arriving in MANUAL is lost.
- **Output invariants.** `key_on` is never 1 in IDLE or GAP. At most one `src_rst` bit is 0 at any time.

## Test plan
Bench uses `GAP_CYCLES`=4 and stub players whose `key_on`/`key` are driven directly.
1. **Start a song.** Reset, then `play_req` with `song_sel`=2 in IDLE → next edge: `mode`=10, `src_rst`=4'b1011, `cur_song`=2. `key` tracks `src_key[11:8]` with 1-cycle latency.
2. **Manual preemption.** `man_key_on`=1, `man_key`=5 during SONG → GAP for exactly 4 cycles with `key_on`=0 and `src_rst`=4'b1111. Then MANUAL with `key`=5 and `key_on`=1. Releasing the key gives GAP, then IDLE.
3. **Song switch.** In SONG(2), `play_req` with `song_sel`=1, then a second `play_req` with `song_sel`=3 during GAP → after 4 gap cycles, SONG with `cur_song`=3 and `src_rst`=4'b0111.
4. **Stop and simultaneous events.**
   - `stop_req` together with `play_req` in GAP → ends in IDLE with pending cleared.
   - `man_key_on` together with `stop_req` in SONG → GAP, then MANUAL.
5. **Invalid index.** With `NUM_SONGS`=3, `play_req` with `song_sel`=3 in IDLE → state stays IDLE, `src_rst` stays all ones, `cur_song` unchanged.
6. **Reset mid-gap.** Assert `rst` asynchronously during GAP at `gap_cnt`=2 → outputs return to reset values immediately without a clock edge. After release, `play_req` with `song_sel`=0 enters SONG normally.
